// File: rtl/uart_download.sv
// uart_download: UART receiver (8N1) that buffers received bytes in a circular FIFO.
// Optional macro UART_RX_PARITY_EN selects 8E1 framing and adds a sticky parity_err output.
module uart_download #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 230400,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                        clk_50m,
  input  logic                        rst_n,
  input  logic                        RX,
  input  logic                        rFIFO_rdreq,
  output logic [7:0]                  rFIFO_odata,
  output logic                        rFIFO_empty,
  output logic                        rFIFO_full,
  output logic [$clog2(FIFO_DEPTH):0] rFIFO_usedw,
  output logic                        rx_busy,
  output logic                        frame_err,
  output logic                        overflow,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        clr_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(HALF_DIV);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  logic          rx_meta_q, rx_sync_q, rx_s;
  state_t        state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q, wr_data_q;
  logic          wr_en_q, rx_busy_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_q;
`endif

  // Two-flop synchroniser for the asynchronous serial input, idle-high reset.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end
  assign rx_s = rx_sync_q;

  // Receive FSM: start validation, mid-bit sampling, stop check, write strobe.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      wr_data_q    <= 8'h00;
      wr_en_q      <= 1'b0;
      rx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (clr_err) parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= 3'd0;
          if (!rx_s) begin
            state_q   <= S_START;
            rx_busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (baud_cnt_q == BAUD_HALF) begin
            baud_cnt_q <= '0;
            if (rx_s) begin
              state_q   <= S_IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s, shift_q[7:1]};
            bit_idx_q  <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= S_STOP;
            if (^{shift_q, rx_s}) parity_err_q <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            rx_busy_q  <= 1'b0;
            if (rx_s) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= shift_q;
              state_q   <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  odata_q, odata_d;
  logic        overflow_q, overflow_d;
  logic        empty_s, full_s, rd_ok_s, wr_ok_s;

  // Extra pointer bit distinguishes full from empty; a read frees the slot a full write needs.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok_s = rFIFO_rdreq && !empty_s;
  assign wr_ok_s = wr_en_q && (!full_s || rd_ok_s);

  // FIFO next-state: pointers, read data and sticky overflow (set beats clear).
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    odata_d    = odata_q;
    overflow_d = overflow_q;
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      odata_d  = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (wr_en_q && !wr_ok_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      odata_q    <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      odata_q    <= odata_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk_50m) begin
    if (wr_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_q;
  end

  assign rFIFO_odata = odata_q;
  assign rFIFO_empty = empty_s;
  assign rFIFO_full  = full_s;
  assign rFIFO_usedw = wr_ptr_q - rd_ptr_q;
  assign rx_busy     = rx_busy_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_download.sv
// Directed self-checking bench for uart_download (FIFO_DEPTH=4, default baud).
module tb_uart_download;

  localparam int BIT  = 217;
  localparam int HALF = 108;
`ifdef UART_RX_PARITY_EN
  localparam int NSAMP = 10;
`else
  localparam int NSAMP = 9;
`endif
  // Posedge (counted from the start-bit negedge) at which the FIFO write happens.
  localparam int WR_EDGE = 4 + HALF + BIT * NSAMP + 1;

  logic       clk_50m = 1'b0;
  logic       rst_n, RX, rFIFO_rdreq, clr_err;
  logic [7:0] rFIFO_odata;
  logic       rFIFO_empty, rFIFO_full, rx_busy, frame_err, overflow;
  logic [2:0] rFIFO_usedw;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_bit = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int fe_count = 0;
  int fe_before;

  uart_download #(.FIFO_DEPTH(4)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .RX         (RX),
    .rFIFO_rdreq(rFIFO_rdreq),
    .rFIFO_odata(rFIFO_odata),
    .rFIFO_empty(rFIFO_empty),
    .rFIFO_full (rFIFO_full),
    .rFIFO_usedw(rFIFO_usedw),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overflow   (overflow),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .clr_err    (clr_err)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (frame_err === 1'b1) fe_count <= fe_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Call on a negedge; drives one full frame then returns RX high.
  task automatic send_byte(input logic [7:0] data, input logic stop);
    RX = 1'b0;
    repeat (BIT) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (BIT) @(negedge clk_50m);
    end
`ifdef UART_RX_PARITY_EN
    RX = par_bit;
    repeat (BIT) @(negedge clk_50m);
`endif
    RX = stop;
    repeat (BIT) @(negedge clk_50m);
    RX = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    rFIFO_rdreq = 1'b1;
    @(negedge clk_50m);
    rFIFO_rdreq = 1'b0;
    check_eq(tag, {24'h0, rFIFO_odata}, {24'h0, exp});
  endtask

  initial begin
    rst_n = 1'b0; RX = 1'b1; rFIFO_rdreq = 1'b0; clr_err = 1'b0;
    idle(3);
    check_eq("rst_odata", {24'h0, rFIFO_odata}, 32'h0);
    check_eq("rst_empty", {31'h0, rFIFO_empty}, 32'h1);
    check_eq("rst_full", {31'h0, rFIFO_full}, 32'h0);
    check_eq("rst_usedw", {29'h0, rFIFO_usedw}, 32'h0);
    check_eq("rst_busy", {31'h0, rx_busy}, 32'h0);
    check_eq("rst_ferr", {31'h0, frame_err}, 32'h0);
    check_eq("rst_ovf", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Two back-to-back frames, then read them out.
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    idle(10);
    check_eq("two_usedw", {29'h0, rFIFO_usedw}, 32'h2);
    check_eq("two_empty", {31'h0, rFIFO_empty}, 32'h0);
    pop_check("rd_55", 8'h55);
    pop_check("rd_A3", 8'hA3);
    check_eq("drain_empty", {31'h0, rFIFO_empty}, 32'h1);
    check_eq("drain_usedw", {29'h0, rFIFO_usedw}, 32'h0);
    pop_check("rd_empty_hold", 8'hA3);
    check_eq("empty_rd_usedw", {29'h0, rFIFO_usedw}, 32'h0);

    // Start-bit glitch of 50 clocks.
    RX = 1'b0;
    idle(50);
    check_eq("glitch_busy", {31'h0, rx_busy}, 32'h1);
    RX = 1'b1;
    idle(65);
    check_eq("glitch_idle", {31'h0, rx_busy}, 32'h0);
    check_eq("glitch_usedw", {29'h0, rFIFO_usedw}, 32'h0);
    check_eq("glitch_ferr", fe_count, 32'h0);

    // Stop bit low, then a good frame.
    fe_before = fe_count;
    send_byte(8'h3C, 1'b0);
    idle(20);
    check_eq("ferr_once", fe_count - fe_before, 32'h1);
    check_eq("ferr_usedw", {29'h0, rFIFO_usedw}, 32'h0);
    send_byte(8'h81, 1'b1);
    idle(10);
    check_eq("after_ferr_usedw", {29'h0, rFIFO_usedw}, 32'h1);
    pop_check("rd_81", 8'h81);

    // Overflow with five bytes into a four-deep FIFO.
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    idle(10);
    check_eq("ovf_full", {31'h0, rFIFO_full}, 32'h1);
    check_eq("ovf_usedw", {29'h0, rFIFO_usedw}, 32'h4);
    check_eq("ovf_flag", {31'h0, overflow}, 32'h1);
    for (int b = 1; b <= 4; b++) pop_check("ovf_rd", 8'(b));
    check_eq("ovf_drained", {31'h0, rFIFO_empty}, 32'h1);
    check_eq("ovf_sticky", {31'h0, overflow}, 32'h1);
    clr_err = 1'b1;
    @(negedge clk_50m);
    clr_err = 1'b0;
    check_eq("ovf_clr", {31'h0, overflow}, 32'h0);

    // Full FIFO: read in the same cycle as the write.
    for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 1'b1);
    idle(10);
    check_eq("sim_full", {31'h0, rFIFO_full}, 32'h1);
    fork
      send_byte(8'h15, 1'b1);
      begin
        repeat (WR_EDGE - 1) @(negedge clk_50m);
        rFIFO_rdreq = 1'b1;
        @(negedge clk_50m);
        rFIFO_rdreq = 1'b0;
        check_eq("sim_rd_11", {24'h0, rFIFO_odata}, 32'h11);
        check_eq("sim_usedw", {29'h0, rFIFO_usedw}, 32'h4);
        check_eq("sim_noovf", {31'h0, overflow}, 32'h0);
      end
    join
    idle(10);
    for (int b = 2; b <= 5; b++) pop_check("sim_rd", 8'h10 + 8'(b));
    check_eq("sim_empty", {31'h0, rFIFO_empty}, 32'h1);

`ifdef UART_RX_PARITY_EN
    clr_err = 1'b1;
    @(negedge clk_50m);
    clr_err = 1'b0;
    par_bit = 1'b0;
    send_byte(8'h07, 1'b1);
    idle(10);
    check_eq("par_err_set", {31'h0, parity_err}, 32'h1);
    pop_check("par_rd_07", 8'h07);
    clr_err = 1'b1;
    @(negedge clk_50m);
    clr_err = 1'b0;
    check_eq("par_clr", {31'h0, parity_err}, 32'h0);
    par_bit = 1'b1;
    send_byte(8'h07, 1'b1);
    idle(10);
    check_eq("par_ok", {31'h0, parity_err}, 32'h0);
    pop_check("par_rd_07b", 8'h07);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
